// File: rtl/eth_pkg.sv
// Shared encodings for the Ethernet TX path: FSM state codes, framing bytes, saturating counter helper.
package eth_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_SFD      = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_DRAIN    = 3'd4;
  localparam logic [2:0] ST_IFG      = 3'd5;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin frame arbiter: grant latched while i_start and a request is present, one cycle.
// History moves only on i_frame_end, so a grant is never pre-empted mid-frame; reset favours requester 0.
module rr_arbiter_2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_start,
  input  logic       i_frame_end,
  output logic       o_gnt
);

  logic r_gnt;
  logic r_last;
  logic w_pick;

  // On a tie the requester that did not own the previous frame wins.
  assign w_pick = (i_req == 2'b11) ? ~r_last : i_req[1];
  assign o_gnt  = r_gnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gnt  <= 1'b0;
      r_last <= 1'b1;
    end else begin
      if (i_start && (|i_req)) r_gnt <= w_pick;
      if (i_frame_end) r_last <= r_gnt;
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frames one of two byte streams with preamble/SFD onto a 4-cycle-per-byte RMII byte bus, with IFG spacing.
// First tvalid 2 cycles after a request in IDLE; the granted source sees a one-cycle tready per byte period.
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int IFG_BYTES      = 12,
  parameter int PREAMBLE_BYTES = 7
) (
  input  logic       refclk,
  input  logic       sresetn,
  input  logic       s0_axis_tvalid,
  output logic       s0_axis_tready,
  input  logic       s0_axis_tlast,
  input  logic [7:0] s0_axis_tdata,
  input  logic       s1_axis_tvalid,
  output logic       s1_axis_tready,
  input  logic       s1_axis_tlast,
  input  logic [7:0] s1_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic [7:0] m_axis_tdata,
  output logic [7:0] underrun_count
);

  // IDLE and the preamble start-up cycle also keep tvalid low, so the IFG state is two cycles short.
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES * 4 - 3);
  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_BYTES - 1);

  logic [2:0]  r_state;
  logic [1:0]  r_phase;
  logic [15:0] r_cnt;
  logic        r_tvalid;
  logic        r_tlast;
  logic [7:0]  r_tdata;
  logic [1:0]  r_tready;
  logic [7:0]  r_underrun;

  logic [1:0]  w_req;
  logic        w_gnt;
  logic        w_s_vld;
  logic        w_s_last;
  logic [7:0]  w_s_dat;
  logic        w_rdy;
  logic        w_acc;
  logic        w_period_end;
  logic        w_req_load;
  logic        w_frame_end;
  logic        w_arb_start;

  assign w_req        = {s1_axis_tvalid, s0_axis_tvalid};
  assign w_s_vld      = w_gnt ? s1_axis_tvalid : s0_axis_tvalid;
  assign w_s_last     = w_gnt ? s1_axis_tlast  : s0_axis_tlast;
  assign w_s_dat      = w_gnt ? s1_axis_tdata  : s0_axis_tdata;
  assign w_rdy        = w_gnt ? r_tready[1]    : r_tready[0];
  assign w_acc        = w_s_vld & w_rdy;
  assign w_period_end = r_tvalid & (r_phase == 2'd3);
  // No fetch during the period that already carries the frame's last byte.
  assign w_req_load   = r_tvalid & (r_phase == 2'd2) &
                        ((r_state == ST_SFD) | ((r_state == ST_DATA) & ~r_tlast));
  assign w_frame_end  = ((r_state == ST_DATA) & w_period_end & r_tlast) |
                        ((r_state == ST_DRAIN) & w_acc & w_s_last);
  assign w_arb_start  = (r_state == ST_IDLE);

  rr_arbiter_2 u_arb (
    .i_clk       (refclk),
    .i_rst_n     (sresetn),
    .i_req       (w_req),
    .i_start     (w_arb_start),
    .i_frame_end (w_frame_end),
    .o_gnt       (w_gnt)
  );

  always_ff @(posedge refclk or negedge sresetn) begin
    if (!sresetn) begin
      r_state    <= ST_IDLE;
      r_phase    <= 2'd0;
      r_cnt      <= 16'd0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_tdata    <= 8'h00;
      r_tready   <= 2'b00;
      r_underrun <= 8'h00;
    end else begin
      if (r_tvalid) r_phase <= r_phase + 2'd1;
      case (r_state)
        ST_IDLE: begin
          if (|w_req) r_state <= ST_PREAMBLE;
        end
        ST_PREAMBLE: begin
          if (!r_tvalid) begin
            r_tvalid <= 1'b1;
            r_tdata  <= PREAMBLE_BYTE;
            r_cnt    <= 16'd0;
          end else if (w_period_end) begin
            if (r_cnt == PRE_LAST) begin
              r_state <= ST_SFD;
              r_tdata <= SFD_BYTE;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        ST_SFD, ST_DATA: begin
          if (w_req_load) r_tready[w_gnt] <= 1'b1;
          if (w_period_end) begin
            if ((r_state == ST_DATA) && r_tlast) begin
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_state  <= ST_IFG;
              r_cnt    <= 16'd0;
            end else if (w_acc) begin
              r_tdata  <= w_s_dat;
              r_tlast  <= w_s_last;
              r_tready <= 2'b00;
              r_state  <= ST_DATA;
            end else begin
              // Source starved: stop at this byte boundary and keep tready up to flush the rest.
              r_tvalid   <= 1'b0;
              r_underrun <= sat_inc8(r_underrun);
              r_state    <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_acc && w_s_last) begin
            r_tready <= 2'b00;
            r_state  <= ST_IFG;
            r_cnt    <= 16'd0;
          end
        end
        ST_IFG: begin
          if (r_cnt == IFG_LAST) r_state <= ST_IDLE;
          else                   r_cnt   <= r_cnt + 16'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_axis_tvalid  = r_tvalid;
  assign m_axis_tlast   = r_tlast;
  assign m_axis_tdata   = r_tdata;
  assign s0_axis_tready = r_tready[0];
  assign s1_axis_tready = r_tready[1];
  assign underrun_count = r_underrun;

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 SHALL have parameter IFG_BYTES, default 12, inter-frame gap length in byte periods.
REQ-002 SHALL have parameter PREAMBLE_BYTES, default 7, count of 0x55 bytes before SFD.
REQ-003 SHALL have port refclk  input  1  50 MHz clock, sole clock.
REQ-004 SHALL have port sresetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports s0_axis_tvalid/tready/tlast  in/out/in  1 each  requester 0 frame stream.
REQ-006 SHALL have port s0_axis_tdata  input  8  requester 0 byte.
REQ-007 SHALL have ports s1_axis_tvalid/tready/tlast/tdata, same as s0, for requester 1.
REQ-008 SHALL have ports m_axis_tvalid, m_axis_tlast  output  1  to RMII serializer; tvalid drives tx_en.
REQ-009 SHALL have port m_axis_tdata  output  8  byte to serializer.
REQ-010 SHALL have port underrun_count  output  8  saturating count of aborted frames.

Function
REQ-011 SHALL run a 2-bit phase counter, incremented each cycle m_axis_tvalid=1, so one byte period = 4 refclk cycles.
REQ-012 SHALL hold m_axis_tdata stable for a whole byte period and change it only when phase wraps 3->0.
REQ-013 SHALL deassert m_axis_tvalid only at phase 3->0 boundary, so the serializer's dibit counter stays byte-aligned.
REQ-014 SHALL implement states IDLE, PREAMBLE, SFD, DATA, DRAIN, IFG.
REQ-015 IDLE: any requester tvalid -> grant and go to PREAMBLE next cycle; no tready asserted.
REQ-016 SHALL arbitrate round-robin per frame: both valid -> grant the requester not granted last; reset favours s0.
REQ-017 PREAMBLE: m_axis_tdata=0x55, m_axis_tvalid=1 for PREAMBLE_BYTES periods, then SFD.
REQ-018 SFD: m_axis_tdata=0xD5 for one period, then DATA.
REQ-019 DATA: granted tready pulses exactly one cycle at phase 3 of each period to load the next byte; non-granted tready=0.
REQ-020 First payload byte SHALL be loaded at phase 3 of the SFD period.
REQ-021 m_axis_tlast SHALL be 1 for the whole period carrying the byte loaded with tlast=1; after it, go to IFG.
REQ-022 Underrun: granted tvalid=0 at a load point in DATA/SFD -> m_axis_tvalid=0 from next period, underrun_count+1 (saturate 255), go to DRAIN.
REQ-023 DRAIN: granted tready=1 continuously; discard bytes until a tlast beat is accepted, then IFG.
REQ-024 IFG: m_axis_tvalid=0 for IFG_BYTES*4 cycles, then IDLE; requests arriving meanwhile wait.
REQ-025 Requests arriving mid-frame SHALL NOT pre-empt; grant held until IFG ends.
REQ-026 tlast on a beat while tvalid=0 SHALL be ignored.

Reset
REQ-027 sresetn=0 SHALL asynchronously force: state IDLE, phase 0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0x00, both tready=0, underrun_count=0, last-grant=s1 (so s0 wins first tie).
REQ-028 Reset mid-frame SHALL truncate output immediately; no IFG enforced after release.
REQ-029 Outputs SHALL be registered; first m_axis_tvalid no earlier than 2 cycles after sresetn deasserts.

Structure
REQ-030 SHALL place state encoding, PREAMBLE_BYTE (0x55), SFD_BYTE (0xD5) in shared package eth_pkg.
REQ-031 SHALL contain one sub-module rr_arbiter_2 (2-way round-robin, grant on request, update on frame end).
REQ-032 SHALL instantiate no FIFO; buffering is one byte register.

Verification
REQ-033 s0 frame 0x01,0x02,0x03(tlast) from reset -> 7x0x55, 0xD5, 0x01,0x02,0x03 each 4 cycles, tlast only on 0x03, then 48 idle cycles.
REQ-034 s0 and s1 both valid continuously, 2 frames each -> order s0,s1,s0,s1, each separated by exactly 48 tvalid=0 cycles.
REQ-035 s1 drops tvalid for 4 cycles after byte 2 of 5 -> tvalid falls at period boundary, underrun_count=1, remaining s1 bytes drained, next frame preamble after 48 cycles.
REQ-036 sresetn pulsed low during payload byte 3 -> m_axis_tvalid=0 same cycle, after release s1 pending frame begins with preamble within 2 cycles.
REQ-037 Every m_axis_tvalid high run length SHALL be a multiple of 4 cycles (assertion across all tests).
REQ-038 300 forced underruns -> underrun_count holds 255.
